lz77_encoder_stream: RTL and testbench

LZ77_ENCODER_STREAM -- requirements
Module: lz77_encoder_stream

---
 rtl/lz77_encoder_stream_if.sv | 22 ++
 rtl/lz77_encoder_stream.sv | 207 ++++++++++++++++++++
 tb/tb_lz77_encoder_stream.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lz77_encoder_stream_if.sv
// Character-in / token-out handshake bundle for lz77_encoder_stream.
// master drives characters and observes tokens; slave is the encoder.
interface lz77_encoder_stream_if;
  logic       in_valid;
  logic [7:0] char_in;
  logic       in_ready;
  logic       encode;
  logic [3:0] code_pos;
  logic [2:0] code_len;
  logic [7:0] chardata;
  logic       finish;

  modport master (
    output in_valid, char_in,
    input  in_ready, encode, code_pos, code_len, chardata, finish
  );

  modport slave (
    input  in_valid, char_in,
    output in_ready, encode, code_pos, code_len, chardata, finish
  );
endinterface

// File: rtl/lz77_encoder_stream.sv
// Streaming LZ77 encoder: 9-entry search buffer, 8-entry lookahead, '$'-terminated input.
// Define LZ77_ENC_OVERLAP_EN to let matches run from history into the lookahead.
module lz77_encoder_stream #(
  parameter int SB_DEPTH = 9,
  parameter int LA_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  lz77_encoder_stream_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FILL   = 3'd1;
  localparam logic [2:0] SEARCH = 3'd2;
  localparam logic [2:0] EMIT   = 3'd3;
  localparam logic [2:0] SHIFT  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam logic [7:0] TERM    = 8'h24;
  localparam logic [3:0] LA_FULL = 4'(LA_DEPTH);
  localparam logic [3:0] SB_FULL = 4'(SB_DEPTH);
  localparam logic [3:0] MAX_LEN = 4'(LA_DEPTH - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] l_q [LA_DEPTH];
  logic [7:0] l_d [LA_DEPTH];
  logic [7:0] h_q [SB_DEPTH];
  logic [7:0] h_d [SB_DEPTH];
  logic [3:0] lcount_q, lcount_d;
  logic [3:0] hcount_q, hcount_d;
  logic [3:0] p_q, p_d;
  logic [2:0] best_len_q, best_len_d;
  logic [3:0] best_pos_q, best_pos_d;
  logic [2:0] emit_cnt_q, emit_cnt_d;
  logic       term_buf_q, term_buf_d;
  logic [3:0] code_pos_q, code_pos_d;
  logic [2:0] code_len_q, code_len_d;
  logic [7:0] chardata_q, chardata_d;

  logic [3:0] cap;
  logic [2:0] len_p;
  logic       run;
  logic       hit;
  logic [2:0] tok_len;
  logic [3:0] tok_pos;
  logic [3:0] shift_n;
  logic [4:0] hsum;

  // Match length at the offset under evaluation. h_q[i] holds the char i+1 positions back.
  always_comb begin
    cap = (lcount_q - 4'd1 > MAX_LEN) ? MAX_LEN : lcount_q - 4'd1;
`ifndef LZ77_ENC_OVERLAP_EN
    if (p_q < cap) cap = p_q;
`endif
    len_p = '0;
    run   = 1'b1;
    hit   = 1'b0;
    for (int k = 0; k < LA_DEPTH - 1; k++) begin
      hit = 1'b0;
      if (4'(k) < p_q) hit = (l_q[3'(k)] == h_q[4'(p_q - 4'(k) - 4'd1)]);
`ifdef LZ77_ENC_OVERLAP_EN
      else hit = (l_q[3'(k)] == l_q[3'(4'(k) - p_q)]);
`endif
      if (run && (4'(k) < cap) && hit) len_p = len_p + 3'd1;
      else run = 1'b0;
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves one unassigned (no latches).
    state_d    = state_q;
    l_d        = l_q;
    h_d        = h_q;
    lcount_d   = lcount_q;
    hcount_d   = hcount_q;
    p_d        = p_q;
    best_len_d = best_len_q;
    best_pos_d = best_pos_q;
    emit_cnt_d = emit_cnt_q;
    term_buf_d = term_buf_q;
    code_pos_d = code_pos_q;
    code_len_d = code_len_q;
    chardata_d = chardata_q;

    // Strictly-greater update while p ascends keeps the smallest offset on ties.
    tok_len = best_len_q;
    tok_pos = best_pos_q;
    if (hcount_q == 4'd0) begin
      tok_len = '0;
      tok_pos = '0;
    end else if (len_p > best_len_q) begin
      tok_len = len_p;
      tok_pos = p_q;
    end

    shift_n = {1'b0, code_len_q} + 4'd1;
    hsum    = {1'b0, hcount_q} + {1'b0, shift_n};

    case (state_q)
      IDLE: state_d = FILL;

      FILL: begin
        if (bus.in_valid) begin
          l_d[lcount_q[2:0]] = bus.char_in;
          lcount_d = lcount_q + 4'd1;
          if (bus.char_in == TERM) term_buf_d = 1'b1;
          if ((lcount_q + 4'd1 == LA_FULL) || (bus.char_in == TERM)) begin
            state_d    = SEARCH;
            p_d        = 4'd1;
            best_len_d = '0;
            best_pos_d = '0;
          end
        end
      end

      SEARCH: begin
        best_len_d = tok_len;
        best_pos_d = tok_pos;
        if ((hcount_q == 4'd0) || (p_q == hcount_q)) begin
          state_d    = EMIT;
          code_pos_d = tok_pos;
          code_len_d = tok_len;
          chardata_d = l_q[tok_len];
          emit_cnt_d = tok_len;
        end else begin
          p_d = p_q + 4'd1;
        end
      end

      EMIT: begin
        if (emit_cnt_q == 3'd0) state_d = SHIFT;
        else emit_cnt_d = emit_cnt_q - 3'd1;
      end

      SHIFT: begin
        // Consumed chars enter history newest-first; the rest of history slides back.
        for (int j = 0; j < SB_DEPTH; j++) begin
          if (4'(j) < shift_n) h_d[4'(j)] = l_q[3'(shift_n - 4'(j) - 4'd1)];
          else h_d[4'(j)] = h_q[4'(4'(j) - shift_n)];
        end
        for (int i = 0; i < LA_DEPTH; i++) begin
          if (4'(i) + shift_n < LA_FULL) l_d[3'(i)] = l_q[3'(4'(i) + shift_n)];
          else l_d[3'(i)] = 8'h00;
        end
        lcount_d = lcount_q - shift_n;
        hcount_d = (hsum > {1'b0, SB_FULL}) ? SB_FULL : hsum[3:0];
        if (chardata_q == TERM) begin
          state_d = DONE;
        end else if (term_buf_q) begin
          state_d    = SEARCH;
          p_d        = 4'd1;
          best_len_d = '0;
          best_pos_d = '0;
        end else begin
          state_d = FILL;
        end
      end

      DONE: state_d = DONE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    if (!reset) begin
      state_q    <= IDLE;
      lcount_q   <= '0;
      hcount_q   <= '0;
      p_q        <= '0;
      best_len_q <= '0;
      best_pos_q <= '0;
      emit_cnt_q <= '0;
      term_buf_q <= 1'b0;
      code_pos_q <= '0;
      code_len_q <= '0;
      chardata_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      lcount_q   <= lcount_d;
      hcount_q   <= hcount_d;
      p_q        <= p_d;
      best_len_q <= best_len_d;
      best_pos_q <= best_pos_d;
      emit_cnt_q <= emit_cnt_d;
      term_buf_q <= term_buf_d;
      code_pos_q <= code_pos_d;
      code_len_q <= code_len_d;
      chardata_q <= chardata_d;
    end
  end

  // NOTE: buffer contents are not reset; lcount/hcount alone decide which entries are live.
  always_ff @(posedge clk) begin
    l_q <= l_d;
    h_q <= h_d;
  end

  assign bus.in_ready = (state_q == FILL);
  assign bus.encode   = (state_q == EMIT);
  assign bus.finish   = (state_q == DONE);
  assign bus.code_pos = code_pos_q;
  assign bus.code_len = code_len_q;
  assign bus.chardata = chardata_q;

endmodule

// File: tb/tb_lz77_encoder_stream.sv
// Self-checking bench for lz77_encoder_stream: whole-stream LZ77 model, per-cycle token compare,
// literal pins for the reference streams, random streams with random input gaps.
module tb_lz77_encoder_stream;

  typedef struct packed {
    logic [3:0] pos;
    logic [2:0] len;
    logic [7:0] ch;
  } tok_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lz77_encoder_stream_if bus_if ();

  lz77_encoder_stream #(.SB_DEPTH(9), .LA_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] stim_q[$];
  tok_t       model_q[$];
  tok_t       lit_q[$];
  tok_t       exp_q[$];
  tok_t       cur_tok;
  tok_t       last_tok;
  int         run_len;
  bit         chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic tok_t tk(input int p, input int l, input logic [7:0] c);
    return {4'(p), 3'(l), c};
  endfunction

  function automatic tok_t dut_tok();
    return {bus_if.code_pos, bus_if.code_len, bus_if.chardata};
  endfunction

  // Whole-stream LZ77: history = up to 9 previous chars, lookahead = up to 8 chars ending at '$'.
  function automatic void build_model();
    int term, cur, la, hc, cap0, cap, len, best_len, best_pos;
    model_q.delete();
    term = stim_q.size() - 1;
    cur  = 0;
    for (int guard = 0; guard < 1000; guard++) begin
      la   = (term - cur + 1 < 8) ? term - cur + 1 : 8;
      hc   = (cur < 9) ? cur : 9;
      cap0 = (la - 1 < 7) ? la - 1 : 7;
      best_len = 0;
      best_pos = 0;
      for (int p = 1; p <= hc; p++) begin
        cap = cap0;
`ifndef LZ77_ENC_OVERLAP_EN
        if (p < cap) cap = p;
`endif
        len = 0;
        while (len < cap && stim_q[cur + len] == stim_q[cur + len - p]) len++;
        if (len > best_len) begin
          best_len = len;
          best_pos = p;
        end
      end
      model_q.push_back(tk(best_pos, best_len, stim_q[cur + best_len]));
      if (stim_q[cur + best_len] == 8'h24) break;
      cur += best_len + 1;
    end
  endfunction

  task automatic set_stream(input logic [63:0] v, input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic rand_stream();
    int n;
    bit wide;
    logic [7:0] c;
    stim_q.delete();
    n    = $urandom_range(0, 30);
    wide = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < n; i++) begin
      c = wide ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      if (c == 8'h24) c = 8'h25;
      stim_q.push_back(c);
    end
    stim_q.push_back(8'h24);
  endtask

  task automatic pin(input string name);
    build_model();
    check({name, "_count"}, model_q.size(), lit_q.size());
    for (int i = 0; i < model_q.size() && i < lit_q.size(); i++)
      check(name, model_q[i], lit_q[i]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_encode"},   bus_if.encode,   1'b0);
    check({tag, "_in_ready"}, bus_if.in_ready, 1'b0);
    check({tag, "_code_pos"}, bus_if.code_pos, 4'd0);
    check({tag, "_code_len"}, bus_if.code_len, 3'd0);
    check({tag, "_chardata"}, bus_if.chardata, 8'h00);
    check({tag, "_finish"},   bus_if.finish,   1'b0);
  endtask

  task automatic do_reset();
    chk_en          = 1'b0;
    reset           = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.char_in  = 8'h00;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
  endtask

  // gap_pct < 0 selects the fixed 1-0-0-1 in_valid pattern.
  task automatic send_stream(input int gap_pct);
    int idx = 0;
    int cyc = 0;
    while (idx < stim_q.size() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (gap_pct < 0) bus_if.in_valid = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
      else bus_if.in_valid = !(gap_pct > 0 && $urandom_range(0, 99) < gap_pct);
      bus_if.char_in = stim_q[idx];
      #1;
      if (bus_if.in_valid && bus_if.in_ready) idx++;
    end
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    check("chars_accepted", idx, stim_q.size());
  endtask

  task automatic run_stream(input int gap_pct);
    build_model();
    do_reset();
    exp_q    = model_q;
    run_len  = 0;
    last_tok = '0;
    chk_en   = 1'b1;
    send_stream(gap_pct);
    for (int c = 0; c < 2000 && !bus_if.finish; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    check("tokens_left", exp_q.size(), 0);
    check("finish", bus_if.finish, 1'b1);
  endtask

  // Per-cycle compare against the model's token queue.
  always @(negedge clk) begin
    if (chk_en) begin
      if (bus_if.encode) begin
        if (run_len == 0) begin
          if (exp_q.size() == 0) check("unexpected_token", 1, 0);
          else cur_tok = exp_q.pop_front();
        end
        check("token", dut_tok(), cur_tok);
        check("in_ready_while_encode", bus_if.in_ready, 1'b0);
        check("finish_while_encode", bus_if.finish, 1'b0);
        run_len++;
        last_tok = cur_tok;
      end else begin
        if (run_len != 0) begin
          check("hold_cycles", run_len, int'(cur_tok.len) + 1);
          run_len = 0;
        end
        check("token_kept", dut_tok(), last_tok);
        if (bus_if.finish) check("finish_early", exp_q.size(), 0);
      end
    end
  end

  initial begin
    reset           = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.char_in  = 8'h00;

    // Reset asserted while a token is on the bus.
    set_stream(64'h0101010124, 5);
    do_reset();
    send_stream(0);
    for (int c = 0; c < 100 && !bus_if.encode; c++) @(negedge clk);
    check("encode_seen", bus_if.encode, 1'b1);
    #2 reset = 1'b0;
    #1 check_outputs_zero("mid_emit_reset");
    @(negedge clk);
    reset = 1'b1;

    set_stream(64'h0124, 2);
    lit_q.delete();
    lit_q.push_back(tk(0, 0, 8'h01));
    lit_q.push_back(tk(0, 0, 8'h24));
    pin("pin_01_24");
    run_stream(0);

    set_stream(64'h0001020324, 5);
    lit_q.delete();
    for (int i = 0; i < 4; i++) lit_q.push_back(tk(0, 0, 8'(i)));
    lit_q.push_back(tk(0, 0, 8'h24));
    pin("pin_literals");
    run_stream(0);

    set_stream(64'h0101010124, 5);
    lit_q.delete();
    lit_q.push_back(tk(0, 0, 8'h01));
`ifdef LZ77_ENC_OVERLAP_EN
    lit_q.push_back(tk(1, 3, 8'h24));
`else
    lit_q.push_back(tk(1, 1, 8'h01));
    lit_q.push_back(tk(1, 1, 8'h24));
`endif
    pin("pin_run_of_01");
    run_stream(0);

    set_stream(64'h020302030224, 6);
    lit_q.delete();
    lit_q.push_back(tk(0, 0, 8'h02));
    lit_q.push_back(tk(0, 0, 8'h03));
`ifdef LZ77_ENC_OVERLAP_EN
    lit_q.push_back(tk(2, 3, 8'h24));
`else
    lit_q.push_back(tk(2, 2, 8'h02));
    lit_q.push_back(tk(0, 0, 8'h24));
`endif
    pin("pin_period2");
    run_stream(0);
    run_stream(-1);

    set_stream(64'h05050524, 4);
    lit_q.delete();
    lit_q.push_back(tk(0, 0, 8'h05));
`ifdef LZ77_ENC_OVERLAP_EN
    lit_q.push_back(tk(1, 2, 8'h24));
`else
    lit_q.push_back(tk(1, 1, 8'h05));
    lit_q.push_back(tk(0, 0, 8'h24));
`endif
    pin("pin_tie_break");
    run_stream(0);

    for (int r = 0; r < 40; r++) begin
      rand_stream();
      run_stream($urandom_range(0, 60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
